// File: rtl/csr_regfile_pkg.sv
// csr_regfile_pkg
// Shared constants for the LoongArch CSR file: CSR numbers, field positions,
// writable-bit masks and the exception codes WB commits. Also carries the
// CRMD layout and the masked-write helper used by every software-writable
// register.
package csr_regfile_pkg;

    // CSR numbers
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    // Field positions
    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;
    localparam int TICLR_CLR     = 0;
    localparam int ESTAT_IS_TI   = 11;

    // ECFG.LIE: bit 10 does not exist and always reads 0
    localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;

    // Exception codes used by WB
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    // CRMD layout, MSB first
    typedef struct packed {
        logic       pg;
        logic       da;
        logic       ie;
        logic [1:0] plv;
    } crmd_t;

    localparam crmd_t CRMD_RESET = 5'b01000;

    function automatic logic [31:0] masked_write(input logic [31:0] old_value,
                                                 input logic [31:0] mask,
                                                 input logic [31:0] value);
        return (old_value & ~mask) | (value & mask);
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// csr_regfile_if
// Bundle between the WB stage (master) and the CSR file (slave).
//   master drives: csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, wb_ex,
//                  ertn_flush, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
//                  hw_int_in, ipi_int_in
//   slave drives:  csr_rvalue, has_int, ex_entry, ertn_entry
interface csr_regfile_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] wb_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_vaddr;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
               wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
               hw_int_in, ipi_int_in,
        input  csr_rvalue, has_int, ex_entry, ertn_entry
    );

    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
               wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
               hw_int_in, ipi_int_in,
        output csr_rvalue, has_int, ex_entry, ertn_entry
    );
endinterface

// File: rtl/csr_regfile_timer.sv
// csr_timer
// Constant timer: owns TCFG, TVAL and the timer interrupt bit ESTAT.IS[11].
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tcfg_we, ticlr_we decoded software write strobes (already priority-gated)
//   wmask, wvalue     write mask / data shared with the rest of the CSR file
//   tcfg, tval        current register values for the read mux
//   timer_is          timer interrupt status
module csr_timer
    import csr_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tcfg_we,
    input  logic        ticlr_we,
    input  logic [31:0] wmask,
    input  logic [31:0] wvalue,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        timer_is
);

    logic [31:0] tcfg_next;
    logic        timer_fire;

    assign tcfg_next = masked_write(tcfg, wmask, wvalue);

    // The cycle of a TCFG write is reserved for the reload, so the
    // countdown (and therefore the interrupt) only runs on other cycles.
    assign timer_fire = !tcfg_we && tcfg[TCFG_EN] && (tval == 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tcfg     <= '0;
            tval     <= '0;
            timer_is <= 1'b0;
        end else begin
            if (tcfg_we) begin
                tcfg <= tcfg_next;
            end

            if (tcfg_we) begin
                if (tcfg_next[TCFG_EN]) begin
                    tval <= {tcfg_next[31:2], 2'b00};
                end
            end else if (tcfg[TCFG_EN]) begin
                if (tval != 32'd0) begin
                    tval <= tval - 32'd1;
                end else if (tcfg[TCFG_PERIODIC]) begin
                    tval <= {tcfg[31:2], 2'b00};
                end
            end

            // A new expiry outranks a simultaneous software clear
            if (timer_fire) begin
                timer_is <= 1'b1;
            end else if (ticlr_we && wmask[TICLR_CLR] && wvalue[TICLR_CLR]) begin
                timer_is <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// csr_regfile
// LoongArch control/status register file sitting after WB. Holds CRMD, PRMD,
// ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3 and TID; the timer registers live
// in csr_timer. Provides the combinational read port, exception/ertn commit
// updates, the interrupt request and the fetch redirect targets.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       csr_regfile_if slave: CSR read/write, commit info, interrupt
//             lines in; csr_rvalue, has_int, ex_entry, ertn_entry out
module csr_regfile
    import csr_regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    csr_regfile_if.slave  bus
);

    crmd_t       crmd;
    logic [1:0]  prmd_pplv;
    logic        prmd_pie;
    logic [12:0] ecfg_lie;
    logic [1:0]  is_sw;
    logic [7:0]  is_hw;
    logic        is_ipi;
    logic [5:0]  estat_ecode;
    logic [8:0]  estat_esubcode;
    logic [31:0] era;
    logic [31:0] badv;
    logic [25:0] eentry_va;
    logic [31:0] save0, save1, save2, save3;
    logic [31:0] tid;

    logic [31:0] tcfg;
    logic [31:0] tval;
    logic        timer_is;

    logic        sw_we;
    logic        tcfg_we;
    logic        ticlr_we;
    logic [12:0] is_all;
    logic [31:0] estat_value;
    logic [31:0] raw_rdata;
    logic [31:0] merged;

    // Commit events take the whole cycle; a CSR write alongside is dropped
    assign sw_we    = bus.csr_we && !bus.wb_ex && !bus.ertn_flush;
    assign tcfg_we  = sw_we && (bus.csr_num == CSR_TCFG);
    assign ticlr_we = sw_we && (bus.csr_num == CSR_TICLR);

    assign is_all      = {is_ipi, timer_is, 1'b0, is_hw, is_sw};
    assign estat_value = {1'b0, estat_esubcode, estat_ecode, 3'b000, is_all};

    always_comb begin
        raw_rdata = '0;
        case (bus.csr_num)
            CSR_CRMD:   raw_rdata = {27'b0, crmd};
            CSR_PRMD:   raw_rdata = {29'b0, prmd_pie, prmd_pplv};
            CSR_ECFG:   raw_rdata = {19'b0, ecfg_lie};
            CSR_ESTAT:  raw_rdata = estat_value;
            CSR_ERA:    raw_rdata = era;
            CSR_BADV:   raw_rdata = badv;
            CSR_EENTRY: raw_rdata = {eentry_va, 6'b0};
            CSR_SAVE0:  raw_rdata = save0;
            CSR_SAVE1:  raw_rdata = save1;
            CSR_SAVE2:  raw_rdata = save2;
            CSR_SAVE3:  raw_rdata = save3;
            CSR_TID:    raw_rdata = tid;
            CSR_TCFG:   raw_rdata = tcfg;
            CSR_TVAL:   raw_rdata = tval;
            default:    raw_rdata = '0;
        endcase
    end

    // The read mux output doubles as the "old" value for the masked merge;
    // each register then keeps only the bits it actually implements.
    assign merged = masked_write(raw_rdata, bus.csr_wmask, bus.csr_wvalue);

    assign bus.csr_rvalue = bus.csr_re ? raw_rdata : 32'b0;
    assign bus.has_int    = crmd.ie && |(is_all & ecfg_lie);
    assign bus.ex_entry   = {eentry_va, 6'b0};
    assign bus.ertn_entry = era;

    always_ff @(posedge clk) begin
        if (rst) begin
            crmd           <= CRMD_RESET;
            prmd_pplv      <= '0;
            prmd_pie       <= 1'b0;
            ecfg_lie       <= '0;
            is_sw          <= '0;
            is_hw          <= '0;
            is_ipi         <= 1'b0;
            estat_ecode    <= '0;
            estat_esubcode <= '0;
            era            <= '0;
            badv           <= '0;
            eentry_va      <= '0;
            save0          <= '0;
            save1          <= '0;
            save2          <= '0;
            save3          <= '0;
            tid            <= '0;
        end else begin
            is_hw  <= bus.hw_int_in;
            is_ipi <= bus.ipi_int_in;

            if (bus.wb_ex) begin
                prmd_pplv      <= crmd.plv;
                prmd_pie       <= crmd.ie;
                crmd.plv       <= 2'b00;
                crmd.ie        <= 1'b0;
                estat_ecode    <= bus.wb_ecode;
                estat_esubcode <= bus.wb_esubcode;
                era            <= bus.wb_pc;
                if (bus.wb_ecode == ECODE_ADE || bus.wb_ecode == ECODE_ALE) begin
                    badv <= bus.wb_vaddr;
                end
            end else if (bus.ertn_flush) begin
                crmd.plv <= prmd_pplv;
                crmd.ie  <= prmd_pie;
            end else if (sw_we) begin
                case (bus.csr_num)
                    CSR_CRMD:   crmd      <= merged[4:0];
                    CSR_PRMD:   {prmd_pie, prmd_pplv} <= merged[2:0];
                    CSR_ECFG:   ecfg_lie  <= merged[12:0] & ECFG_LIE_MASK;
                    CSR_ESTAT:  is_sw     <= merged[1:0];
                    CSR_ERA:    era       <= merged;
                    CSR_BADV:   badv      <= merged;
                    CSR_EENTRY: eentry_va <= merged[31:6];
                    CSR_SAVE0:  save0     <= merged;
                    CSR_SAVE1:  save1     <= merged;
                    CSR_SAVE2:  save2     <= merged;
                    CSR_SAVE3:  save3     <= merged;
                    CSR_TID:    tid       <= merged;
                    default: ;
                endcase
            end
        end
    end

    csr_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .tcfg_we  (tcfg_we),
        .ticlr_we (ticlr_we),
        .wmask    (bus.csr_wmask),
        .wvalue   (bus.csr_wvalue),
        .tcfg     (tcfg),
        .tval     (tval),
        .timer_is (timer_is)
    );

endmodule

// File: doc/csr_regfile.md
# csr_regfile

- Control/status register file for the LoongArch pipelined CPU.
- Sits directly downstream of the WB stage and consumes its CSR access and exception/ertn commit signals; returns `csr_rvalue` to WB in the same cycle.
- Holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0–3, TID, TCFG, TVAL and TICLR, runs the constant timer, and produces the interrupt request and redirect targets for the fetch stage.

## Interface
Parameters:
- none; CSR numbers, field positions and ECODE values come from `macro.h`.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `csr_re`  in  1  read enable. When low, `csr_rvalue` = 0.
- `csr_num`  in  14  CSR number, shared by read and write.
- `csr_rvalue`  out  32  combinational read of current (pre-write) state.
- `csr_we`  in  1  write enable.
- `csr_wmask`  in  32  per-bit write mask.
- `csr_wvalue`  in  32  write data.
- `wb_ex`  in  1  exception commit.
- `ertn_flush`  in  1  ertn commit.
- `wb_pc`  in  32  PC of the committing instruction.
- `wb_ecode`  in  6  exception code.
- `wb_esubcode`  in  9  exception subcode.
- `wb_vaddr`  in  32  faulting address.
- `hw_int_in`  in  8  hardware interrupt lines, level.
- `ipi_int_in`  in  1  inter-processor interrupt, level.
- `has_int`  out  1  pending enabled interrupt.
- `ex_entry`  out  32  exception target, equals EENTRY.
- `ertn_entry`  out  32  ertn target, equals ERA.

## Operation
Register fields and reset values (all other bits read 0 and ignore writes):
- CRMD (0x0): PLV[1:0], IE[2], DA[3], PG[4]; reset 0x0000_0008.
- PRMD (0x1): PPLV[1:0], PIE[2]; reset 0.
- ECFG (0x4): LIE[9:0] and LIE[12:11]; bit 10 is hardwired 0; reset 0.
- ESTAT (0x5): IS[1:0] software-writable; IS[9:2] = `hw_int_in` sampled every cycle; IS[11] timer; IS[12] = `ipi_int_in` sampled every cycle; Ecode[21:16] and EsubCode[30:22] written by hardware only; reset 0.
- ERA (0x6), BADV (0x7), SAVE0–3 (0x30–0x33), TID (0x40): full 32 bits; reset 0.
- EENTRY (0xC): VA[31:6] only; reset 0.
- TCFG (0x41): En[0], Periodic[1], InitVal[31:2]; reset 0.
- TVAL (0x42): read-only; reset 0.
- TICLR (0x44): reads 0. Writing 1 to bit 0 (mask bit 0 set) clears IS[11].

Software write:
- For writable bits: new = (old & ~mask) | (wvalue & mask).
- Writes to unknown numbers are dropped; reads of unknown numbers return 0.

Exception (`wb_ex`=1):
- PRMD.PPLV ← CRMD.PLV; PRMD.PIE ← CRMD.IE.
- CRMD.PLV ← 0; CRMD.IE ← 0.
- ESTAT.Ecode ← `wb_ecode`; ESTAT.EsubCode ← `wb_esubcode`.
- ERA ← `wb_pc`.
- BADV ← `wb_vaddr` only when `wb_ecode` is ADE or ALE.

ertn (`ertn_flush`=1, `wb_ex`=0):
- CRMD.PLV ← PRMD.PPLV; CRMD.IE ← PRMD.PIE.

Priority:
- `wb_ex` > `ertn_flush` > `csr_we`.
- `csr_we` is fully ignored in any cycle where `wb_ex` or `ertn_flush` is high.

Timer (sub-module):
- On a TCFG write whose resulting En=1: TVAL ← {InitVal_new, 2'b00}. No decrement that cycle.
- Otherwise, if En=1 and TVAL≠0: TVAL ← TVAL−1. If TVAL==1 at that point, set IS[11].
- Otherwise, if En=1 and TVAL==0: Periodic=1 reloads {InitVal,2'b00}; Periodic=0 holds 0.
- En=0 freezes TVAL.
- Set and TICLR clear of IS[11] in the same cycle: set wins.

Outputs:
- `has_int` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).

## Timing
- Reads are combinational from registered state. A read and write to the same CSR in one cycle (csrxchg) returns the old value; the new value is visible next cycle.
- All updates take effect at the clock edge of the commit cycle.
- `ex_entry` and `ertn_entry` are valid the same cycle that `wb_ex`/`ertn_flush` is asserted, so fetch redirects without a bubble.
- `hw_int_in` and `ipi_int_in` reach `has_int` one cycle after they change.
- Timer period with Periodic=1 is 4·InitVal+1 cycles. InitVal=0 never fires.
- Reset mid-operation: the next edge forces all registers to their reset values, which pulls `has_int`, `ex_entry` and `ertn_entry` to 0.
- `csr_rvalue` is 0 during reset because `csr_re` is low from WB.

## Structure
- `macro.h` holds:
  - all CSR numbers (`CSR_CRMD` … `CSR_TICLR`);
  - field bit positions and widths;
  - the ECODE/ESUBCODE constants WB already uses.
- One sub-module, `csr_timer`:
  - owns TCFG, TVAL and the IS[11] set/clear logic;
  - receives the decoded TCFG/TICLR write strobes plus mask/value;
  - exports tcfg, tval and timer_is.
- The top level holds every other register, the read mux and the priority logic.

## Test plan
- Reset then read CRMD → 0x0000_0008. Read TVAL, ESTAT, ERA → 0. `has_int`=0.
- Write SAVE1 with wvalue 0xFFFF_FFFF, mask 0x0000_FF00 → next read 0x0000_FF00. Read in the same cycle as a second write returns the old value.
- CRMD=0x7; `wb_ex` with ecode ALE, pc 0x1c00_0100, vaddr 0x1234_5671 →
  - CRMD=0x0 and PRMD=0x7;
  - ERA=0x1c00_0100 and BADV=0x1234_5671;
  - Ecode=0x09.
  - Then `ertn_flush` → CRMD=0x7. `ertn_entry`=0x1c00_0100.
- `wb_ex` and `csr_we` to SAVE0 in the same cycle → SAVE0 unchanged.
- TCFG write 0x0000_000B (InitVal=2, Periodic, En) → TVAL counts 8,7,…,1,0 and IS[11] sets on the 1→0 step. The next cycle reloads 8. With ECFG.LIE[11]=1 and CRMD.IE=1, `has_int`=1. A TICLR write of 1 clears IS[11] and drops `has_int` next cycle.
- `hw_int_in`=0x01 with LIE[2]=1 and IE=1 → `has_int`=1 one cycle later. Clearing IE drops it next cycle. Asserting `rst` mid-count → TVAL=0 and TCFG=0.
